bsr_tap_ctrl: RTL

Single-clock IEEE 1149.1-style TAP controller that sequences a chain of `DW_bc_1` boundary-scan cells. It decodes `tms`/`tdi` into the cell control strobes (`capture_en`, `shift_dr`, `update_en`, `mode`) and holds an instruction register and a 1-bit bypass register. It routes the selected serial path to a registered `tdo`. It sits between the chip test port and the boundary-scan register (BSR), with `clk` driving both this block and the cells' `capture_clk`/`update_clk`.

---
 rtl/bsr_tap_pkg.sv | 33 +++
 rtl/bsr_tap_fsm.sv | 48 ++++
 rtl/bsr_tap_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/bsr_tap_pkg.sv
// Shared types and constants for the boundary-scan TAP controller.
package bsr_tap_pkg;

  // TAP states; encoding follows the customary 1149.1 state numbering.
  typedef enum logic [3:0] {
    StEx2Dr = 4'h0,
    StEx1Dr = 4'h1,
    StShDr  = 4'h2,
    StPaDr  = 4'h3,
    StSelIr = 4'h4,
    StUpdDr = 4'h5,
    StCapDr = 4'h6,
    StSelDr = 4'h7,
    StEx2Ir = 4'h8,
    StEx1Ir = 4'h9,
    StShIr  = 4'hA,
    StPaIr  = 4'hB,
    StRti   = 4'hC,
    StUpdIr = 4'hD,
    StCapIr = 4'hE,
    StTlr   = 4'hF
  } tap_state_t;

  localparam int unsigned DefIrWidth  = 4;
  localparam int unsigned DefOpExtest = 0;
  localparam int unsigned DefOpSample = 1;

  // IR capture pattern: ...0001, so the two LSBs read back as 2'b01.
  function automatic logic [31:0] ir_capture();
    return 32'h0000_0001;
  endfunction

endpackage

// File: rtl/bsr_tap_fsm.sv
// 16-state TAP state machine driven by tms, one transition per clk.
module bsr_tap_fsm
  import bsr_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_q, state_d;

  // State register with synchronous reset into Test-Logic-Reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode on tms.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = tms ? StTlr   : StRti;
      StRti:   state_d = tms ? StSelDr : StRti;
      StSelDr: state_d = tms ? StSelIr : StCapDr;
      StCapDr: state_d = tms ? StEx1Dr : StShDr;
      StShDr:  state_d = tms ? StEx1Dr : StShDr;
      StEx1Dr: state_d = tms ? StUpdDr : StPaDr;
      StPaDr:  state_d = tms ? StEx2Dr : StPaDr;
      StEx2Dr: state_d = tms ? StUpdDr : StShDr;
      StUpdDr: state_d = tms ? StSelDr : StRti;
      StSelIr: state_d = tms ? StTlr   : StCapIr;
      StCapIr: state_d = tms ? StEx1Ir : StShIr;
      StShIr:  state_d = tms ? StEx1Ir : StShIr;
      StEx1Ir: state_d = tms ? StUpdIr : StPaIr;
      StPaIr:  state_d = tms ? StEx2Ir : StPaIr;
      StEx2Ir: state_d = tms ? StUpdIr : StShIr;
      StUpdIr: state_d = tms ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/bsr_tap_ctrl.sv
// TAP controller for a DW_bc_1 boundary-scan chain: IR, bypass, cell strobes, TDO.
module bsr_tap_ctrl
  import bsr_tap_pkg::*;
#(
  parameter int unsigned          IR_WIDTH  = DefIrWidth,
  parameter logic [IR_WIDTH-1:0]  OP_EXTEST = IR_WIDTH'(DefOpExtest),
  parameter logic [IR_WIDTH-1:0]  OP_SAMPLE = IR_WIDTH'(DefOpSample),
  parameter logic [IR_WIDTH-1:0]  OP_BYPASS = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic tms,
  input  logic tdi,
  input  logic bsr_so,
  output logic bsr_si,
  output logic capture_en,
  output logic shift_dr,
  output logic update_en,
  output logic mode,
  output logic tdo,
  output logic tdo_oe,
  output logic tlr
);

  localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(ir_capture());

  tap_state_t state;

  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_shadow_q, ir_shadow_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_oe_q, tdo_oe_d;
  logic                bsr_sel;

  bsr_tap_fsm u_fsm (
    .clk   (clk),
    .rst   (rst),
    .tms   (tms),
    .state (state)
  );

  // Anything other than EXTEST/SAMPLE, including undefined codes, falls back to bypass.
  assign bsr_sel = (ir_shadow_q == OP_EXTEST) || (ir_shadow_q == OP_SAMPLE);

  // Next values for IR, bypass and the TDO pipeline stage.
  always_comb begin
    ir_shift_d  = ir_shift_q;
    ir_shadow_d = ir_shadow_q;
    bypass_d    = bypass_q;
    tdo_d       = tdo_q;
    tdo_oe_d    = 1'b0;
    case (state)
      StTlr:   ir_shadow_d = OP_BYPASS;
      StCapIr: ir_shift_d  = IrCapture;
      StShIr: begin
        ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
        tdo_d      = ir_shift_q[0];
        tdo_oe_d   = 1'b1;
      end
      StUpdIr: ir_shadow_d = ir_shift_q;
      StCapDr: bypass_d    = 1'b0;
      StShDr: begin
        bypass_d = tdi;
        tdo_d    = bsr_sel ? bsr_so : bypass_q;
        tdo_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registers; reset discards any partial IR shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_shift_q  <= '0;
      ir_shadow_q <= OP_BYPASS;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
    end else begin
      ir_shift_q  <= ir_shift_d;
      ir_shadow_q <= ir_shadow_d;
      bypass_q    <= bypass_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
    end
  end

  // Moore decode of the cell strobes; tms never reaches these outputs.
  always_comb begin
    capture_en = 1'b1;
    shift_dr   = 1'b0;
    update_en  = 1'b0;
    if (bsr_sel) begin
      capture_en = (state != StCapDr);
      shift_dr   = (state == StShDr);
      update_en  = (state == StUpdDr);
    end
    mode = (ir_shadow_q == OP_EXTEST) && (state != StTlr);
  end

  assign bsr_si = tdi;
  assign tdo    = tdo_q;
  assign tdo_oe = tdo_oe_q;
  assign tlr    = (state == StTlr);

endmodule
